reg_writeback_unit: RTL and testbench

- Writer side of the 8x10-bit register file. It drives the RegFile write port (write_en, reg_write_dest, write_data).
- Buffers completed results from execute in a small FIFO (valid/ready handshake) and retires one result per cycle into the RegFile.
- Tracks in-flight destinations in a per-register scoreboard. For each decode read port it either forwards not-yet-retired data or raises a hazard (stall).

---
 rtl/reg_writeback_unit.sv | 156 +++++++++++++++
 tb/tb_reg_writeback_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_unit.sv
// Writeback unit: buffers execute results in a small FIFO, retires one per cycle into the
// RegFile, and resolves decode operands against a per-register in-flight scoreboard.
module reg_writeback_unit #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dest,
  output logic              issue_stall,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [ADDR_W-1:0] res_dest,
  input  logic [DATA_W-1:0] res_data,
  output logic              write_en,
  output logic [ADDR_W-1:0] reg_write_dest,
  output logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_addr_1,
  input  logic [ADDR_W-1:0] read_addr_2,
  input  logic [DATA_W-1:0] rf_data_1,
  input  logic [DATA_W-1:0] rf_data_2,
  output logic [DATA_W-1:0] fwd_data_1,
  output logic [DATA_W-1:0] fwd_data_2,
  output logic              hazard_1,
  output logic              hazard_2
);
  localparam int NREG  = 2**ADDR_W;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] fifo_dest_q [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [1:0]        cnt_q [NREG];
  logic [1:0]        cnt_d [NREG];

  logic              empty_s, full_s, push_s, pop_s, issue_acc_s;
  logic [ADDR_W-1:0] head_dest_s;
  logic [ADDR_W-1:0] raddr_s [2];
  logic [DATA_W-1:0] rf_s    [2];
  logic [DATA_W-1:0] fwd_s   [2];
  logic              hz_s    [2];
  logic [CNT_W-1:0]  match_s [2];
  logic [DATA_W-1:0] young_s [2];

  function automatic logic [PTR_W-1:0] slot(input logic [PTR_W-1:0] base, input int unsigned off);
    return base + PTR_W'(off);
  endfunction

  assign empty_s     = (count_q == {CNT_W{1'b0}});
  assign full_s      = (count_q == CNT_W'(DEPTH));
  assign res_ready   = !full_s;
  assign push_s      = res_valid && !full_s;
  assign pop_s       = !empty_s;
  assign head_dest_s = fifo_dest_q[rd_ptr_q];
  assign issue_stall = issue_valid && (cnt_q[issue_dest] == 2'd3);
  assign issue_acc_s = issue_valid && !issue_stall;

  assign raddr_s[0] = read_addr_1;
  assign raddr_s[1] = read_addr_2;
  assign rf_s[0]    = rf_data_1;
  assign rf_s[1]    = rf_data_2;
  assign fwd_data_1 = fwd_s[0];
  assign fwd_data_2 = fwd_s[1];
  assign hazard_1   = hz_s[0];
  assign hazard_2   = hz_s[1];

  // RegFile write port driven straight from the FIFO head
  always_comb begin
    write_en       = 1'b0;
    reg_write_dest = {ADDR_W{1'b0}};
    write_data     = {DATA_W{1'b0}};
    if (!empty_s && !reset) begin
      write_en       = 1'b1;
      reg_write_dest = head_dest_s;
      write_data     = fifo_data_q[rd_ptr_q];
    end else begin
      write_en       = 1'b0;
    end
  end

  // FIFO pointer and occupancy next-state
  always_comb begin
    rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Scoreboard next-state: claim on accepted issue, release on retirement
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (issue_acc_s && (issue_dest == ADDR_W'(r)) && !(pop_s && (head_dest_s == ADDR_W'(r)))) begin
        cnt_d[r] = cnt_q[r] + 2'd1;
      end else if (pop_s && (head_dest_s == ADDR_W'(r)) && !(issue_acc_s && (issue_dest == ADDR_W'(r)))
                   && (cnt_q[r] != 2'd0)) begin
        cnt_d[r] = cnt_q[r] - 2'd1;
      end else begin
        cnt_d[r] = cnt_q[r];
      end
    end
  end

  // Operand resolution: a claim not covered by a buffered result is a hazard
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      match_s[p] = {CNT_W{1'b0}};
      young_s[p] = rf_s[p];
      for (int i = 0; i < DEPTH; i++) begin
        if ((CNT_W'(i) < count_q) && (fifo_dest_q[slot(rd_ptr_q, i)] == raddr_s[p])) begin
          match_s[p] = match_s[p] + CNT_W'(1);
          young_s[p] = fifo_data_q[slot(rd_ptr_q, i)];
        end else begin
          match_s[p] = match_s[p];
        end
      end
      if ({{CNT_W{1'b0}}, cnt_q[raddr_s[p]]} > {2'b00, match_s[p]}) begin
        hz_s[p]  = 1'b1;
        fwd_s[p] = rf_s[p];
      end else begin
        hz_s[p]  = 1'b0;
        fwd_s[p] = young_s[p];
      end
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= {PTR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      for (int r = 0; r < NREG; r++) cnt_q[r] <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  // FIFO payload storage; contents are only meaningful below count_q
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      fifo_dest_q[wr_ptr_q] <= res_dest;
      fifo_data_q[wr_ptr_q] <= res_data;
    end
  end
endmodule

// File: tb/tb_reg_writeback_unit.sv
// Self-checking bench for reg_writeback_unit: hand-derived vector table plus random
// traffic checked against a queue-based reference model.
module tb_reg_writeback_unit;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       reset, issue_valid, issue_stall, res_valid, res_ready, write_en, hazard_1, hazard_2;
  logic [2:0] issue_dest, res_dest, reg_write_dest, read_addr_1, read_addr_2;
  logic [9:0] res_data, write_data, rf_data_1, rf_data_2, fwd_data_1, fwd_data_2;

  int n_cmp = 0;
  int n_bad = 0;

  reg_writeback_unit dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_dest(issue_dest),
    .issue_stall(issue_stall), .res_valid(res_valid), .res_ready(res_ready),
    .res_dest(res_dest), .res_data(res_data), .write_en(write_en),
    .reg_write_dest(reg_write_dest), .write_data(write_data),
    .read_addr_1(read_addr_1), .read_addr_2(read_addr_2),
    .rf_data_1(rf_data_1), .rf_data_2(rf_data_2),
    .fwd_data_1(fwd_data_1), .fwd_data_2(fwd_data_2),
    .hazard_1(hazard_1), .hazard_2(hazard_2)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [2:0] d; logic [9:0] v; } ent_t;
  typedef struct {
    logic rst; logic iv; logic [2:0] id; logic rv; logic [2:0] rd; logic [9:0] rdat;
    logic [2:0] a1; logic [2:0] a2;
    logic e_we; logic [2:0] e_dest; logic [9:0] e_wdata; logic e_st; logic e_rdy;
    logic e_h1; logic e_h2;
    int m1; logic [9:0] f1; int m2; logic [9:0] f2;   // mode 0 skip, 1 rf value, 2 given value
  } vec_t;

  ent_t       q[$];
  int         cnt_m[8];
  logic [9:0] rf_m[8];
  vec_t       tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic resolve(input logic [2:0] a, input logic [9:0] rf, output bit hz, output logic [9:0] f);
    int m = 0;
    f = rf;
    foreach (q[i]) if (q[i].d == a) begin m++; f = q[i].v; end
    hz = (cnt_m[a] > m);
    if (hz) f = rf;
  endtask

  function automatic vec_t mk(input logic rst, iv, input logic [2:0] id, input logic rv,
                              input logic [2:0] rd, input logic [9:0] rdat, input logic [2:0] a1, a2,
                              input logic we, input logic [2:0] wd, input logic [9:0] wdat,
                              input logic st, rdy, h1, h2, input int m1, input logic [9:0] f1,
                              input int m2, input logic [9:0] f2);
    vec_t v;
    v.rst = rst; v.iv = iv; v.id = id; v.rv = rv; v.rd = rd; v.rdat = rdat; v.a1 = a1; v.a2 = a2;
    v.e_we = we; v.e_dest = wd; v.e_wdata = wdat; v.e_st = st; v.e_rdy = rdy; v.e_h1 = h1; v.e_h2 = h2;
    v.m1 = m1; v.f1 = f1; v.m2 = m2; v.f2 = f2;
    return v;
  endfunction

  task automatic step(input vec_t v, input bit chk_tbl, input bit chk_mdl);
    bit         e_we, e_st, e_rdy, h1, h2, pushed, popped;
    logic [2:0] e_dest;
    logic [9:0] e_data, f1, f2;
    ent_t       e;
    int         n;
    reset = v.rst; issue_valid = v.iv; issue_dest = v.id;
    res_valid = v.rv; res_dest = v.rd; res_data = v.rdat;
    read_addr_1 = v.a1; read_addr_2 = v.a2;
    rf_data_1 = rf_m[v.a1]; rf_data_2 = rf_m[v.a2];
    #2;
    e_we   = !v.rst && (q.size() > 0);
    e_dest = e_we ? q[0].d : 3'd0;
    e_data = e_we ? q[0].v : 10'd0;
    e_rdy  = (q.size() < DEPTH);
    e_st   = v.iv && (cnt_m[v.id] == 3);
    resolve(v.a1, rf_data_1, h1, f1);
    resolve(v.a2, rf_data_2, h2, f2);
    if (chk_mdl) begin
      chk("write_en", write_en, e_we);
      chk("reg_write_dest", reg_write_dest, e_dest);
      chk("write_data", write_data, e_data);
      chk("res_ready", res_ready, e_rdy);
      chk("issue_stall", issue_stall, e_st);
      chk("hazard_1", hazard_1, h1);
      chk("hazard_2", hazard_2, h2);
      if (!h1) chk("fwd_data_1", fwd_data_1, f1);
      if (!h2) chk("fwd_data_2", fwd_data_2, f2);
    end
    if (chk_tbl) begin
      chk("tbl_write_en", write_en, v.e_we);
      chk("tbl_dest", reg_write_dest, v.e_dest);
      chk("tbl_wdata", write_data, v.e_wdata);
      chk("tbl_stall", issue_stall, v.e_st);
      chk("tbl_ready", res_ready, v.e_rdy);
      chk("tbl_hazard_1", hazard_1, v.e_h1);
      chk("tbl_hazard_2", hazard_2, v.e_h2);
      if (v.m1 == 1) chk("tbl_fwd1_rf", fwd_data_1, rf_m[v.a1]);
      if (v.m1 == 2) chk("tbl_fwd1", fwd_data_1, v.f1);
      if (v.m2 == 1) chk("tbl_fwd2_rf", fwd_data_2, rf_m[v.a2]);
      if (v.m2 == 2) chk("tbl_fwd2", fwd_data_2, v.f2);
    end
    @(posedge clk);
    if (v.rst) begin
      q.delete();
      foreach (cnt_m[r]) cnt_m[r] = 0;
    end else begin
      pushed = v.rv && (q.size() < DEPTH);
      popped = (q.size() > 0);
      if (popped) begin
        e = q.pop_front();
        rf_m[e.d] = e.v;
      end
      foreach (cnt_m[r]) begin
        n = cnt_m[r];
        if (v.iv && !e_st && v.id == 3'(r)) n++;
        if (popped && e.d == 3'(r)) n--;
        cnt_m[r] = (n < 0) ? 0 : n;
      end
      if (pushed) q.push_back({v.rd, v.rdat});
    end
    #1;
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < 8; i++) rf_m[i] = 10'h200 + 10'(i * 17);
    foreach (cnt_m[r]) cnt_m[r] = 0;
    // initial reset, state unknown before it, so nothing is compared
    step(mk(1,0,0,0,0,0,0,0, 0,0,0, 0,1,0,0, 0,0,0,0), 1'b0, 1'b0);
    //        rst iv id rv rd rdat   a1 a2  we wd wdat   st rdy h1 h2  m1 f1  m2 f2
    tbl.push_back(mk(1,0,0,0,0,0,     0,0,  0,0,0,      0,1, 0,0,  1,0,   1,0));
    tbl.push_back(mk(0,0,0,0,0,0,     0,0,  0,0,0,      0,1, 0,0,  1,0,   1,0));
    tbl.push_back(mk(0,1,3,0,0,0,     3,0,  0,0,0,      0,1, 0,0,  1,0,   1,0));
    tbl.push_back(mk(0,0,0,1,3,10'h003,3,0, 0,0,0,      0,1, 1,0,  0,0,   1,0));
    tbl.push_back(mk(0,0,0,0,0,0,     3,0,  1,3,10'h003,0,1, 0,0,  2,10'h003,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,     3,0,  0,0,0,      0,1, 0,0,  2,10'h003,1,0));
    tbl.push_back(mk(0,1,5,0,0,0,     5,0,  0,0,0,      0,1, 0,0,  1,0,   1,0));
    tbl.push_back(mk(0,1,5,0,0,0,     5,0,  0,0,0,      0,1, 1,0,  0,0,   1,0));
    tbl.push_back(mk(0,1,5,0,0,0,     5,0,  0,0,0,      0,1, 1,0,  0,0,   1,0));
    tbl.push_back(mk(0,1,5,0,0,0,     5,0,  0,0,0,      1,1, 1,0,  0,0,   1,0));
    tbl.push_back(mk(0,1,5,1,5,10'h055,5,0, 0,0,0,      1,1, 1,0,  0,0,   1,0));
    tbl.push_back(mk(0,0,0,0,0,0,     5,0,  1,5,10'h055,0,1, 1,0,  0,0,   1,0));
    tbl.push_back(mk(0,1,5,0,0,0,     5,0,  0,0,0,      0,1, 1,0,  0,0,   1,0));
    tbl.push_back(mk(0,1,2,0,0,0,     0,2,  0,0,0,      0,1, 0,0,  1,0,   1,0));
    tbl.push_back(mk(0,1,2,0,0,0,     0,2,  0,0,0,      0,1, 0,1,  1,0,   0,0));
    tbl.push_back(mk(0,0,0,1,2,10'h0A5,0,2, 0,0,0,      0,1, 0,1,  1,0,   0,0));
    tbl.push_back(mk(0,0,0,1,2,10'h3C3,0,2, 1,2,10'h0A5,0,1, 0,1,  1,0,   0,0));
    tbl.push_back(mk(0,0,0,0,0,0,     0,2,  1,2,10'h3C3,0,1, 0,0,  1,0,   2,10'h3C3));
    tbl.push_back(mk(0,0,0,0,0,0,     0,2,  0,0,0,      0,1, 0,0,  1,0,   2,10'h3C3));
    tbl.push_back(mk(0,0,0,1,1,10'h011,0,0, 0,0,0,      0,1, 0,0,  1,0,   1,0));
    tbl.push_back(mk(0,0,0,1,1,10'h022,0,0, 1,1,10'h011,0,1, 0,0,  1,0,   1,0));
    tbl.push_back(mk(1,0,0,1,1,10'h033,0,0, 0,0,0,      0,1, 0,0,  1,0,   1,0));
    tbl.push_back(mk(0,1,5,0,0,0,     5,1,  0,0,0,      0,1, 0,0,  1,0,   2,10'h011));
    tbl.push_back(mk(0,1,4,0,0,0,     4,0,  0,0,0,      0,1, 0,0,  1,0,   1,0));
    tbl.push_back(mk(0,0,0,1,4,10'h044,4,0, 0,0,0,      0,1, 1,0,  0,0,   1,0));
    tbl.push_back(mk(0,1,4,0,0,0,     4,0,  1,4,10'h044,0,1, 0,0,  2,10'h044,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,     4,0,  0,0,0,      0,1, 1,0,  0,0,   1,0));
    tbl.push_back(mk(0,0,0,0,0,0,     4,0,  0,0,0,      0,1, 1,0,  0,0,   1,0));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b1, 1'b1);

    // random traffic with occasional mid-stream resets
    step(mk(1,0,0,0,0,0,0,0, 0,0,0, 0,1,0,0, 0,0,0,0), 1'b0, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      v = mk(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), 10'($urandom),
             3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
             0,0,0, 0,1,0,0, 0,0,0,0);
      step(v, 1'b0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
